instr_issue_queue: RTL
======================

Name: instr_issue_queue

Overview:
- Sits directly downstream of the instruction fetch stage and upstream of the execution unit.
- Captures each valid 64-bit fetch response as an opcode pair and buffers it in a FIFO.
- Serialises the buffer into a single-opcode valid/ready issue stream, low word first.
- Detects PIPE_HALT at the queue head, stops issue, and generates a fetch-stall for backpressure, since fetch has no ready input.

Parameters:
- DEPTH, 8, number of opcode-pair entries; power of two, at least 4.
- SKID, 2, entries reserved for fetch requests already in flight when fetch_stall asserts.
- OPCODE_WIDTH, 32, width of one opcode.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- opcode_vld  input  1  fetch response valid; single-cycle, no handshake.
- opcode1  input  OPCODE_WIDTH  older opcode of the pair (fetch data[31:0]).
- opcode2  input  OPCODE_WIDTH  younger opcode of the pair (fetch data[63:32]).
- flush  input  1  thread deactivate or redirect; discards all state.
- issue_vld  output  1  issue_opcode is valid.
- issue_opcode  output  OPCODE_WIDTH  opcode to the execution unit.
- issue_rdy  input  1  execution unit accepts the opcode this cycle.
- fetch_stall  output  1  to be ORed into the fetch stage's icache_busy.
- halt_seen  output  1  one-cycle pulse when PIPE_HALT reaches the head.
- q_count  output  $clog2(DEPTH+1)  number of occupied pair entries.
- overflow_err  output  1  sticky flag: a fetch response was dropped.

Behaviour:
- Reset: clk and reset form a single synchronous domain; reset is sampled on the rising clk edge and is active-high.
- Reset values: issue_vld=0, issue_opcode=0, fetch_stall=0, halt_seen=0, q_count=0, overflow_err=0, state=RUN, slot=0, pointers=0.
- Storage: a circular FIFO of DEPTH entries, each {opcode2, opcode1}, with wrapping write/read pointers and an explicit count.
- Head slot bit: 0 selects opcode1, 1 selects opcode2.
- Push: when opcode_vld=1 and state=RUN, write the pair and increment count.
  - Accepted if count<DEPTH, or if a pop happens in the same cycle.
  - Otherwise the pair is dropped and overflow_err is set.
- In HALTED state, opcode_vld is ignored and is not an error.
- Latency: a pair pushed in cycle N is presented on issue_vld in cycle N+1. There is no bypass.
- Issue: issue_vld = RUN & count>0 & head_op != PIPE_HALT.
  - head_op = slot ? opcode2 : opcode1 of the head entry.
  - issue_opcode = head_op when issue_vld, else 0.
- Accept (issue_vld & issue_rdy):
  - If slot=0: set slot=1.
  - If slot=1: pop the entry and set slot=0.
- issue_opcode must hold stable while issue_vld=1 and issue_rdy=0.
- An opcode of value 0 inside a valid pair is issued normally. No filtering.
- States:
  - RUN to HALTED when count>0 & head_op==PIPE_HALT & !flush.
    - On the transition edge, halt_seen pulses for exactly one cycle, and the FIFO, count and slot are cleared.
    - PIPE_HALT itself is never issued. Younger opcodes, including the second slot of the halting pair, are discarded.
  - HALTED to RUN on flush.
  - HALTED ignores everything else. issue_vld=0 and fetch_stall=0 while HALTED.
- flush (highest priority): next cycle count=0, slot=0, pointers=0, state=RUN, overflow_err=0, halt_seen=0.
  - A push in the same cycle as flush is discarded.
- fetch_stall = RUN & (count >= DEPTH-SKID).
  - Decoded from registers only; no combinational path from any input.
- Simultaneous push and pop at count==DEPTH: both occur and count stays DEPTH.
- Count wraps never. Pointer wrap is modulo DEPTH.

Decomposition:
- The shared package holds opcode_t (OPCODE_WIDTH bits) and the PIPE_HALT encoding. The package is already shared with the fetch stage; do not redefine either here.
- One natural sub-module: issue_pair_fifo, a generic DEPTH x 2*OPCODE_WIDTH circular FIFO with push, pop, count, full and empty.
  - instr_issue_queue wraps it with the slot serialiser, halt FSM, stall and error logic.

Test Plan:
- Reset, then push {opcode2=0x22, opcode1=0x11} with issue_rdy=1 -> cycle+1 issue 0x11, cycle+2 issue 0x22, then issue_vld=0 and q_count=0.
- issue_rdy=0 for 5 cycles after one push -> issue_opcode holds 0x11 stable with issue_vld=1. Release rdy -> 0x11 then 0x22, in order.
- Push 8 pairs with rdy=0 -> fetch_stall=1 when q_count reaches 6. A 9th push sets overflow_err=1 and leaves q_count at 8. A 9th push in the same cycle as a slot-1 pop is accepted and q_count stays 8.
- Push {PIPE_HALT, 0x33} then {0x44, 0x55} -> 0x33 issued. Then halt_seen pulses one cycle, q_count=0, and 0x55 and 0x44 are never issued. A subsequent push is ignored until flush.
- Push 3 pairs, assert flush together with a push -> next cycle q_count=0, issue_vld=0, overflow_err=0, and the push is discarded.
- Reset asserted mid-queue (q_count=5, slot=1) -> next cycle all outputs 0 and a new push issues from slot 0.

Source files
------------

// File: rtl/instr_issue_queue_pkg.sv
// Types shared between the fetch stage and the instruction issue queue.
// The halt encoding must match the one the fetch stage produces.
package instr_issue_queue_pkg;

  localparam int unsigned OpcodeBits = 32;

  typedef logic [OpcodeBits-1:0] opcode_t;

  localparam opcode_t PIPE_HALT = 32'h0010_0073;

  typedef enum logic [0:0] {
    StRun,
    StHalted
  } iq_state_e;

endpackage

// File: rtl/instr_issue_queue_if.sv
// Fetch-response, issue-stream and status signals of the instruction issue queue.
// The queue uses the slave modport; whoever drives fetch data and issue_rdy uses master.
interface instr_issue_queue_if
  import instr_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned OPCODE_WIDTH = OpcodeBits
);
  localparam int unsigned CountWidth = $clog2(DEPTH + 1);

  logic                    opcode_vld;
  logic [OPCODE_WIDTH-1:0] opcode1;
  logic [OPCODE_WIDTH-1:0] opcode2;
  logic                    flush;
  logic                    issue_vld;
  logic [OPCODE_WIDTH-1:0] issue_opcode;
  logic                    issue_rdy;
  logic                    fetch_stall;
  logic                    halt_seen;
  logic [CountWidth-1:0]   q_count;
  logic                    overflow_err;

  modport master (
    output opcode_vld, opcode1, opcode2, flush, issue_rdy,
    input  issue_vld, issue_opcode, fetch_stall, halt_seen, q_count, overflow_err
  );

  modport slave (
    input  opcode_vld, opcode1, opcode2, flush, issue_rdy,
    output issue_vld, issue_opcode, fetch_stall, halt_seen, q_count, overflow_err
  );

endinterface

// File: rtl/instr_issue_queue_pair_fifo.sv
// Generic circular FIFO with explicit occupancy count and a synchronous clear.
// The caller must not push when full unless it pops in the same cycle, nor pop when empty.
module issue_pair_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrWidth   = $clog2(DEPTH),
  localparam int unsigned CountWidth = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic [CountWidth-1:0] count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [PtrWidth-1:0]   wr_ptr_q;
  logic [PtrWidth-1:0]   rd_ptr_q;
  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CountWidth'(push) - CountWidth'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CountWidth'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers fetched opcode pairs and issues them one opcode at a time, low word first.
// A PIPE_HALT at the head stops issue and discards everything younger until flush.
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SKID         = 2,
  parameter int unsigned OPCODE_WIDTH = OpcodeBits
) (
  input logic               clk,
  input logic               reset,
  instr_issue_queue_if.slave bus
);

  localparam int unsigned CountWidth = $clog2(DEPTH + 1);
  localparam int unsigned PairWidth  = 2 * OPCODE_WIDTH;
  localparam logic [CountWidth-1:0] StallLevel = CountWidth'(DEPTH - SKID);
  localparam logic [OPCODE_WIDTH-1:0] HaltOp   = OPCODE_WIDTH'(PIPE_HALT);

  iq_state_e state_q, state_d;
  logic      slot_q, slot_d;
  logic      halt_seen_q, halt_seen_d;
  logic      ovf_q, ovf_d;

  logic [PairWidth-1:0]    head_pair;
  logic [OPCODE_WIDTH-1:0] head_op;
  logic [CountWidth-1:0]   count;
  logic                    full;
  logic                    empty;

  logic run;
  logic head_is_halt;
  logic issue_vld;
  logic accept;
  logic pop;
  logic halt_now;
  logic clear;
  logic push;
  logic drop;

  issue_pair_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PairWidth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata ({bus.opcode2, bus.opcode1}),
    .pop   (pop),
    .rdata (head_pair),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    run          = (state_q == StRun);
    head_op      = slot_q ? head_pair[PairWidth-1:OPCODE_WIDTH] : head_pair[OPCODE_WIDTH-1:0];
    head_is_halt = run && !empty && (head_op == HaltOp);
    issue_vld    = run && !empty && (head_op != HaltOp);
    accept       = issue_vld && bus.issue_rdy;
    pop          = accept && slot_q && !bus.flush;
    halt_now     = head_is_halt && !bus.flush;
    clear        = bus.flush || halt_now;
    // A full queue still takes a pair when the head entry retires in the same cycle.
    push         = bus.opcode_vld && run && !clear && (!full || pop);
    drop         = bus.opcode_vld && run && !bus.flush && full && !pop;
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    halt_seen_d = 1'b0;
    ovf_d       = ovf_q || drop;
    if (bus.flush) begin
      state_d = StRun;
      slot_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (head_is_halt) begin
            state_d     = StHalted;
            slot_d      = 1'b0;
            halt_seen_d = 1'b1;
          end else if (accept) begin
            slot_d = !slot_q;
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      slot_q      <= 1'b0;
      halt_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      halt_seen_q <= halt_seen_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.issue_vld    = issue_vld;
  assign bus.issue_opcode = issue_vld ? head_op : '0;
  assign bus.fetch_stall  = run && (count >= StallLevel);
  assign bus.halt_seen    = halt_seen_q;
  assign bus.q_count      = count;
  assign bus.overflow_err = ovf_q;

  // A stalled opcode may only disappear through flush or reset.
  a_issue_stable: assert property (
    @(posedge clk) disable iff (reset)
    (issue_vld && !bus.issue_rdy && !bus.flush) |=> $stable(bus.issue_opcode)
  );

  a_count_bound: assert property (
    @(posedge clk) disable iff (reset) count <= CountWidth'(DEPTH)
  );

endmodule
